// File: rtl/serv_dbg_ctrl.sv
// Debug run-control sequencer: arbitrates halt sources at instruction boundaries,
// tracks halted/running status and runs the resume handshake toward the debug module.
module serv_dbg_ctrl #(
  parameter bit          RESET_HALT = 1'b0,
  parameter int unsigned ACK_HOLD   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_haltreq,
  input  logic       i_resumereq,
  input  logic       i_ndmreset,
  input  logic       i_ackhavereset,
  input  logic       i_insn_done,
  input  logic       i_ebreak,
  input  logic       i_dcsr_ebreakm,
  input  logic       i_dcsr_step,
  input  logic       i_dret,
  output logic       o_dbg_halt,
  output logic       o_dbg_enter,
  output logic [2:0] o_dbg_cause,
  output logic       o_dbg_reset,
  output logic       o_dbg_step,
  output logic       o_halted,
  output logic       o_running,
  output logic       o_resumeack,
  output logic       o_havereset
);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT_PEND,
    S_HALTED,
    S_RESUME,
    S_STEP
  } state_t;

  localparam state_t     RST_STATE = RESET_HALT ? S_HALTED : S_RUN;
  localparam logic [2:0] RST_CAUSE = RESET_HALT ? 3'd5 : 3'd0;
  localparam logic [3:0] ACK_INIT  = 4'(ACK_HOLD);

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;
  localparam logic [2:0] CAUSE_RSTHALT = 3'd5;

  state_t     state, state_nxt;
  logic [2:0] cause, cause_nxt;
  logic [3:0] ack_cnt, ack_nxt;
  logic       enter_nxt;
  logic       dbg_enter_q;
  logic       resumereq_q;
  logic       havereset_q;
  logic       dbg_reset_q;
  logic       resume_rise;
  logic       ebreak_hit;

  assign resume_rise = i_resumereq & ~resumereq_q;
  assign ebreak_hit  = i_ebreak & i_dcsr_ebreakm;

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    enter_nxt = 1'b0;
    ack_nxt   = (ack_cnt != 4'd0) ? ack_cnt - 4'd1 : ack_cnt;

    // ndmreset only steers the state; the ack counter keeps running down
    if (i_ndmreset) begin
      state_nxt = RST_STATE;
      if (RESET_HALT) cause_nxt = CAUSE_RSTHALT;
    end else begin
      case (state)
        S_RUN: begin
          if (i_insn_done && ebreak_hit) begin
            state_nxt = S_HALTED;
            cause_nxt = CAUSE_EBREAK;
            enter_nxt = 1'b1;
          end else if (i_haltreq) begin
            state_nxt = S_HALT_PEND;
          end
        end
        S_HALT_PEND: begin
          if (i_insn_done) begin
            state_nxt = S_HALTED;
            cause_nxt = ebreak_hit ? CAUSE_EBREAK : CAUSE_HALTREQ;
            enter_nxt = 1'b1;
          end
        end
        S_HALTED: begin
          if (resume_rise || (i_insn_done && i_dret)) begin
            state_nxt = S_RESUME;
            ack_nxt   = ACK_INIT;
          end
        end
        S_RESUME: begin
          if (ack_cnt <= 4'd1) state_nxt = i_dcsr_step ? S_STEP : S_RUN;
        end
        S_STEP: begin
          if (i_insn_done) begin
            state_nxt = S_HALTED;
            cause_nxt = CAUSE_STEP;
            enter_nxt = 1'b1;
          end
        end
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= RST_STATE;
      cause       <= RST_CAUSE;
      ack_cnt     <= 4'd0;
      dbg_enter_q <= 1'b0;
      resumereq_q <= 1'b0;
      havereset_q <= 1'b1;
      dbg_reset_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cause       <= cause_nxt;
      ack_cnt     <= ack_nxt;
      dbg_enter_q <= enter_nxt;
      resumereq_q <= i_resumereq;
      dbg_reset_q <= i_ndmreset;
      if (i_ndmreset)          havereset_q <= 1'b1;
      else if (i_ackhavereset) havereset_q <= 1'b0;
    end
  end

  assign o_dbg_halt  = (state == S_HALTED);
  assign o_halted    = (state == S_HALTED);
  assign o_running   = (state == S_RUN) || (state == S_HALT_PEND) || (state == S_STEP);
  assign o_dbg_step  = (state == S_STEP);
  assign o_dbg_enter = dbg_enter_q;
  assign o_dbg_cause = cause;
  assign o_dbg_reset = dbg_reset_q;
  assign o_resumeack = (ack_cnt != 4'd0);
  assign o_havereset = havereset_q;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// Randomized bench for serv_dbg_ctrl: two instances (run-out-of-reset and halt-out-of-reset)
// share stimulus; a per-instance reference model feeds a halt-event scoreboard and status checks.
module tb_serv_dbg_ctrl;

  localparam int RH0 = 0;
  localparam int AH0 = 2;
  localparam int RH1 = 1;
  localparam int AH1 = 3;

  localparam int M_RUN    = 0;
  localparam int M_PEND   = 1;
  localparam int M_HALTED = 2;
  localparam int M_RESUME = 3;
  localparam int M_STEP   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, haltreq, resumereq, ndmreset, ackhr, insn_done, ebreak, ebm, dstep, dret;

  logic [1:0] dbg_halt, dbg_enter, dbg_reset, dbg_step, halted, running, resumeack, havereset;
  logic [2:0] cause0, cause1;

  serv_dbg_ctrl #(.RESET_HALT(1'b0), .ACK_HOLD(AH0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_haltreq(haltreq), .i_resumereq(resumereq),
    .i_ndmreset(ndmreset), .i_ackhavereset(ackhr), .i_insn_done(insn_done),
    .i_ebreak(ebreak), .i_dcsr_ebreakm(ebm), .i_dcsr_step(dstep), .i_dret(dret),
    .o_dbg_halt(dbg_halt[0]), .o_dbg_enter(dbg_enter[0]), .o_dbg_cause(cause0),
    .o_dbg_reset(dbg_reset[0]), .o_dbg_step(dbg_step[0]), .o_halted(halted[0]),
    .o_running(running[0]), .o_resumeack(resumeack[0]), .o_havereset(havereset[0])
  );

  serv_dbg_ctrl #(.RESET_HALT(1'b1), .ACK_HOLD(AH1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_haltreq(haltreq), .i_resumereq(resumereq),
    .i_ndmreset(ndmreset), .i_ackhavereset(ackhr), .i_insn_done(insn_done),
    .i_ebreak(ebreak), .i_dcsr_ebreakm(ebm), .i_dcsr_step(dstep), .i_dret(dret),
    .o_dbg_halt(dbg_halt[1]), .o_dbg_enter(dbg_enter[1]), .o_dbg_cause(cause1),
    .o_dbg_reset(dbg_reset[1]), .o_dbg_step(dbg_step[1]), .o_halted(halted[1]),
    .o_running(running[1]), .o_resumeack(resumeack[1]), .o_havereset(havereset[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic int rh(input int i);
    return (i == 0) ? RH0 : RH1;
  endfunction

  function automatic int ah(input int i);
    return (i == 0) ? AH0 : AH1;
  endfunction

  // Scoreboard of expected halt-entry causes, one queue per instance.
  int q0[$];
  int q1[$];

  function automatic void push_ev(input int i, input int c);
    if (i == 0) q0.push_back(c);
    else        q1.push_back(c);
  endfunction

  // Reference model state
  int mode[2];
  int ack_left[2];
  int cause_e[2];
  bit prev_rr[2];
  bit hr_e[2];
  bit enter_e[2];
  bit dbgrst_e[2];
  bit started = 1'b0;

  bit m_rise, m_eb;
  int m_old, m_c;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mode[i]     = (rh(i) != 0) ? M_HALTED : M_RUN;
        cause_e[i]  = (rh(i) != 0) ? 5 : 0;
        ack_left[i] = 0;
        prev_rr[i]  = 1'b0;
        hr_e[i]     = 1'b1;
        enter_e[i]  = 1'b0;
        dbgrst_e[i] = 1'b0;
      end else begin
        m_rise     = resumereq && !prev_rr[i];
        m_eb       = ebreak && ebm;
        m_old      = ack_left[i];
        enter_e[i] = 1'b0;
        if (ack_left[i] > 0) ack_left[i]--;
        if (ndmreset) begin
          mode[i] = (rh(i) != 0) ? M_HALTED : M_RUN;
          if (rh(i) != 0) cause_e[i] = 5;
        end else if (mode[i] == M_RUN || mode[i] == M_PEND || mode[i] == M_STEP) begin
          // Halt priority at a boundary: step > ebreak > latched haltreq
          if (insn_done && (mode[i] == M_STEP || m_eb || mode[i] == M_PEND)) begin
            m_c        = (mode[i] == M_STEP) ? 4 : (m_eb ? 1 : 3);
            mode[i]    = M_HALTED;
            cause_e[i] = m_c;
            enter_e[i] = 1'b1;
            push_ev(i, m_c);
          end else if (mode[i] == M_RUN && haltreq) begin
            mode[i] = M_PEND;
          end
        end else if (mode[i] == M_HALTED) begin
          if (m_rise || (insn_done && dret)) begin
            mode[i]     = M_RESUME;
            ack_left[i] = ah(i);
          end
        end else if (mode[i] == M_RESUME) begin
          if (m_old <= 1) mode[i] = dstep ? M_STEP : M_RUN;
        end
        prev_rr[i]  = resumereq;
        dbgrst_e[i] = ndmreset;
        if (ndmreset)   hr_e[i] = 1'b1;
        else if (ackhr) hr_e[i] = 1'b0;
      end
    end
    started = 1'b1;
  end

  // Monitor: status outputs every cycle, halt entries popped from the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] obs, exp;
        int act_cause;
        obs = {dbg_halt[i], halted[i], running[i], dbg_step[i],
               resumeack[i], havereset[i], dbg_reset[i], dbg_enter[i]};
        exp = {mode[i] == M_HALTED, mode[i] == M_HALTED,
               mode[i] == M_RUN || mode[i] == M_PEND || mode[i] == M_STEP,
               mode[i] == M_STEP, ack_left[i] > 0, hr_e[i], dbgrst_e[i], enter_e[i]};
        act_cause = (i == 0) ? int'(cause0) : int'(cause1);
        check("status_vec", i, int'(obs), int'(exp));
        check("halted_and_running", i, int'(halted[i] & running[i]), 0);
        if (mode[i] == M_HALTED) check("cause_while_halted", i, act_cause, cause_e[i]);
        if (dbg_enter[i]) begin
          if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
            check("unexpected_enter", i, 1, 0);
          end else begin
            check("enter_cause", i, act_cause, (i == 0) ? q0.pop_front() : q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; haltreq = 1'b0; resumereq = 1'b0; ndmreset = 1'b0; ackhr = 1'b0;
    insn_done = 1'b0; ebreak = 1'b0; ebm = 1'b0; dstep = 1'b0; dret = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      rst_n     = !(cyc >= 3000 && cyc < 3002);
      insn_done = ($urandom_range(0, 99) < 25);
      ebreak    = ($urandom_range(0, 3) == 0);
      dret      = ($urandom_range(0, 7) == 0);
      ackhr     = ($urandom_range(0, 99) < 5);
      ndmreset  = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 99) < 3) ebm = ~ebm;
      if ($urandom_range(0, 99) < 3) dstep = ~dstep;
      if ($urandom_range(0, 99) < 4) haltreq = ~haltreq;
      if ($urandom_range(0, 99) < 6) resumereq = ~resumereq;
    end
    @(negedge clk);
    insn_done = 1'b0; ndmreset = 1'b0; haltreq = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 0, q0.size(), 0);
    check("scoreboard_drained", 1, q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serv_dbg_ctrl.md
Name: serv_dbg_ctrl

Overview:
- Run-control sequencer for the bit-serial core's debug mode; drives the CSR block's debug-halt, step and debug-reset inputs.
- Arbitrates three halt sources at instruction boundaries: debug-module haltreq, ebreak with dcsr.ebreakm set, and single-step completion.
- Tracks halted/running status and performs the resume handshake toward the debug module.
- Sits between the debug module (DM) and the core's state/CSR logic.

Parameters:
- RESET_HALT, 0: 1 = enter HALTED directly out of reset, with cause 5 (resethaltreq).
- ACK_HOLD, 1: number of cycles o_resumeack is held high (range 1..15).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_haltreq  in  1  DM halt request (level)
- i_resumereq  in  1  DM resume request (level; acted on at its rising edge)
- i_ndmreset  in  1  DM non-debug-module reset request (level)
- i_ackhavereset  in  1  DM clears havereset (pulse)
- i_insn_done  in  1  core instruction boundary (one pulse per retired instruction, at cnt_done)
- i_ebreak  in  1  retiring instruction is ebreak (valid with i_insn_done)
- i_dcsr_ebreakm  in  1  dcsr.ebreakm from CSR block
- i_dcsr_step  in  1  dcsr.step from CSR block
- i_dret  in  1  dret executed in debug program (valid with i_insn_done)
- o_dbg_halt  out  1  to CSR/core: core is in debug mode; core fetches from the debug program
- o_dbg_enter  out  1  one-cycle pulse: capture dpc and dcsr.cause
- o_dbg_cause  out  3  dcsr.cause code; valid while o_halted
- o_dbg_reset  out  1  to CSR/core reset
- o_dbg_step  out  1  step window active (one instruction permitted)
- o_halted  out  1  DM status
- o_running  out  1  DM status
- o_resumeack  out  1  DM resume acknowledge
- o_havereset  out  1  DM sticky reset flag

Behaviour:
- States: RUN, HALT_PEND, HALTED, RESUME, STEP.
- Reset (i_rst_n=0):
  - State = RUN, or HALTED if RESET_HALT=1.
  - o_dbg_halt=0, o_halted=0, o_running=1. If RESET_HALT=1: o_dbg_halt=1, o_halted=1, o_running=0.
  - o_dbg_cause=0, or 5 if RESET_HALT=1.
  - o_havereset=1; o_resumeack=0; o_dbg_enter=0; o_dbg_step=0; o_dbg_reset=0.
  - The resumereq edge detector is cleared.
- RUN:
  - i_haltreq=1 -> HALT_PEND.
  - i_insn_done & i_ebreak & i_dcsr_ebreakm -> HALTED, cause 1. Takes priority over a concurrent haltreq.
- HALT_PEND: waits for the next i_insn_done. On it -> HALTED, cause 1 if ebreak&ebreakm, else cause 3.
- Entry to HALTED:
  - o_dbg_enter pulses for exactly one cycle, in the cycle after the qualifying i_insn_done.
  - o_dbg_halt, o_halted and o_dbg_cause update in that same cycle; o_running=0.
- HALTED:
  - i_insn_done from the debug program is ignored, except when i_dret=1 or on a resume request.
  - A rising edge of i_resumereq, or i_insn_done&i_dret -> RESUME.
- RESUME:
  - o_dbg_halt=0 and o_halted=0 in the cycle after entry.
  - o_resumeack held high for ACK_HOLD cycles.
  - Then -> STEP if i_dcsr_step=1, else RUN with o_running=1.
  - i_resumereq is edge-detected and not re-armed until it deasserts.
- STEP:
  - o_dbg_step=1, o_running=1.
  - On the first i_insn_done -> HALTED, cause 4. Step has the highest priority: it wins over ebreak and haltreq on the same boundary.
  - An ebreak&ebreakm boundary in STEP therefore reports cause 4.
- Priority at any boundary: step(4) > ebreak(1) > haltreq(3).
- ndmreset:
  - While i_ndmreset=1: o_dbg_reset=1, state forced to RUN (HALTED if RESET_HALT), o_havereset set.
  - The DM-side edge detector and o_resumeack are preserved.
- i_ackhavereset: clears o_havereset in the next cycle. If i_ackhavereset and i_ndmreset are high together, the flag stays set.
- haltreq dropped in HALT_PEND before a boundary: the halt is still taken. The request is latched.
- haltreq still high on exit from RESUME: RUN -> HALT_PEND immediately; the core retires one instruction before halting again.
- Invariant: o_halted and o_running are never both 1, and are never both 0 outside RESUME.

Test Plan:
- haltreq=1 in RUN, i_insn_done 5 cycles later -> o_dbg_enter pulse at cycle 6, o_halted=1, o_dbg_cause=3, o_running=0.
- RUN, ebreak boundary with ebreakm=1 while haltreq also asserted -> cause=1. Same boundary with ebreakm=0 -> cause=3 via HALT_PEND.
- HALTED, step=1, resumereq edge -> o_resumeack high ACK_HOLD cycles, o_dbg_step=1, one i_insn_done -> HALTED cause=4. A retiring ebreak(ebreakm=1) in STEP also gives cause=4.
- HALTED, resumereq held high for 20 cycles, step=0 -> exactly one resume. Next halt/resume cycle needs a fresh edge.
- ndmreset pulse during STEP -> o_dbg_reset=1, state RUN, o_havereset=1. ackhavereset -> o_havereset=0 next cycle.
- RESET_HALT=1, i_rst_n low 2 cycles then high -> o_halted=1, o_dbg_cause=5 immediately, no instruction retires before resume.
